ps2_rx_fifo: RTL

Parametrised PS/2 keyboard receiver and successor to the single-byte ps2 receiver. It synchronises the raw ps2_clk/ps2_data lines and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). It checks parity, stop bit and inter-edge timeout, and folds E0 (extended) and F0 (break) prefixes into flags. Decoded key events are buffered in a show-ahead FIFO that core logic (keyboard front-end of the machine) drains with rd_en.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_rx_fifo_sync_fifo.sv | 82 ++++++++
 rtl/ps2_rx_fifo.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver with key-event FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  localparam int KEY_EVT_W = $bits(key_evt_t);

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; the head register keeps the last popped entry while empty.
module sync_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = KEY_EVT_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_nxt;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = i_pop && !w_empty;
  // a push into a full FIFO only succeeds when the head leaves in the same cycle
  assign w_push   = i_push && (!w_full || w_pop);
  assign w_rd_nxt = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_pop) begin
        if (r_count > CW'(1)) begin
          r_head <= r_mem[w_rd_nxt];
        end else if (w_push) begin
          r_head <= i_din;
        end
      end else if (w_push && w_empty) begin
        r_head <= i_din;
      end
    end
  end

  assign o_dout  = r_head;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, 11-bit deframer with timeout, E0/F0 prefix
// folding and a show-ahead key-event FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int PARITY_EN      = 1
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic                          key_rdy,
  output logic [7:0]                    key_out,
  output logic                          key_ext,
  output logic                          key_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow
);

  localparam int              TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_neg_edge;

  rx_state_t   r_state, w_state_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_par_ok, w_par_ok_nxt;
  logic [TW-1:0] r_to_cnt, w_to_nxt;
  logic        w_byte_vld;
  logic        w_err_par;
  logic        w_err_frm;

  logic        r_ext_pend;
  logic        r_brk_pend;
  logic        r_push;
  key_evt_t    r_push_evt;
  logic        r_err_parity;
  logic        r_err_frame;
  logic        r_overflow;

  key_evt_t                   w_head;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                       w_drop;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s   = r_data_sync[SYNC_STAGES-1];
  assign w_neg_edge = r_clk_prev && !w_clk_s;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_ok  <= 1'b0;
      r_to_cnt  <= TO_LOAD;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par_ok  <= w_par_ok_nxt;
      r_to_cnt  <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_ok_nxt  = r_par_ok;
    w_byte_vld    = 1'b0;
    w_err_par     = 1'b0;
    w_err_frm     = 1'b0;
    // down-counter reloads on every edge and idles loaded; terminal count is zero
    if (r_state == IDLE || w_neg_edge) begin
      w_to_nxt = TO_LOAD;
    end else begin
      w_to_nxt = r_to_cnt - TW'(1);
    end

    if (w_neg_edge) begin
      case (r_state)
        IDLE: begin
          if (!w_data_s) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          w_shift_nxt   = {w_data_s, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end
        end
        PARITY: begin
          w_par_ok_nxt = (^r_shift) ^ w_data_s;
          w_state_nxt  = STOP;
        end
        STOP: begin
          if (!w_data_s) begin
            w_err_frm = 1'b1;
          end else if (r_par_ok || (PARITY_EN == 0)) begin
            w_byte_vld = 1'b1;
          end else begin
            w_err_par = 1'b1;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_to_cnt == '0) begin
      w_err_frm   = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_push       <= 1'b0;
      r_push_evt   <= '0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
    end else begin
      r_push       <= 1'b0;
      r_err_parity <= w_err_par;
      r_err_frame  <= w_err_frm;
      if (w_err_par || w_err_frm) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_byte_vld) begin
        if (r_shift == PS2_EXT_PREFIX) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == PS2_BRK_PREFIX) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_push     <= 1'b1;
          r_push_evt <= {r_ext_pend, r_brk_pend, r_shift};
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (KEY_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .i_push  (r_push),
    .i_pop   (rd_en),
    .i_din   (r_push_evt),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_drop = r_push && w_full && !rd_en;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (err_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign key_rdy    = !w_empty;
  assign key_out    = w_head.code;
  assign key_ext    = w_head.ext;
  assign key_brk    = w_head.brk;
  assign fifo_count = w_count;
  assign err_parity = r_err_parity;
  assign err_frame  = r_err_frame;
  assign overflow   = r_overflow;

endmodule
